bitnet_dot_acc: RTL and testbench
=================================

Name: bitnet_dot_acc

Overview:
- Parametrised, pipelined successor to the single-lane FP4 E3M0 shift-add FMA.
- Each accepted beat carries LANES int8 activations and LANES FP4 E3M0 weights. The block forms ±(a << exp) per lane, reduces the terms with an adder tree, and accumulates across a frame with saturation.
- The frame result is emitted on a valid/ready output.
- Sits between the activation/weight streamers and the requantiser in the nf_tpu datapath.

Parameters:
- LANES, 4, products summed per beat; power of two, 1..16.
- A_W, 8, signed activation width.
- ACC_W, 16, signed accumulator/result width; must be ≥ A_W+8.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clears all state.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid&in_ready.
- in_first  in  1  beat starts a new frame.
- in_last  in  1  beat ends the frame.
- a_vec  in  LANES*A_W  signed activations; lane i = bits [i*A_W +: A_W].
- w_vec  in  LANES*4  FP4 E3M0 weights; lane i = bits [i*4 +: 4], bit3 sign, bits2:0 exp.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts.
- out_data  out  ACC_W  signed saturated frame sum.
- out_sat  out  1  saturation occurred at least once in this frame.

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sat=0, accumulator=0, sticky flag=0, all pipeline valids=0. in_ready=1 in the cycle after reset.
- Reset mid-frame: the partial frame and any held result are discarded, with no output.
- Weight decode:
  - w==4'b0000 → term 0.
  - Otherwise term = sext(a) << exp, negated when sign=1.
  - 4'b1000 is -a, not zero.
  - Term width is A_W+8, computed exactly with no truncation.
- Stall: stall = out_valid & ~out_ready. All pipeline registers enable on ~stall. in_ready = ~stall, driven combinationally.
- Pipeline:
  - S1 registers the per-lane terms plus first/last/valid.
  - S2 registers the adder-tree sum, width A_W+8+log2(LANES), exact.
  - S3 performs the accumulator update.
- Accumulator update on S2 valid:
  - base = 0 if first, else acc.
  - raw = base + sum, computed exact at full width.
  - next = clamp(raw) to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Saturation is applied at every beat, not only at frame end.
  - sticky = (first ? 0 : sticky) | (raw out of range).
- Frame end: on a last beat, out_data<=next, out_sat<=sticky_next, out_valid<=1, and acc and sticky are cleared to 0.
- Latency: result visible with out_valid=1 three cycles after the last beat is accepted (accept edge t, out_valid high after edge t+3). Throughput is one beat per cycle with no stall.
- Output handshake:
  - out_data/out_sat stay stable while out_valid & ~out_ready.
  - On out_valid&out_ready, out_valid clears unless a new result loads in the same cycle; in that case out_valid stays 1 with the new data.
- Frame boundaries:
  - in_first on the same beat as in_last gives a one-beat frame.
  - in_first mid-frame discards the partial accumulation.
  - A beat after last without in_first starts from 0, because acc was already cleared.
- Input qualification: in_valid low inserts bubbles; first/last/data are ignored when not accepted.

Test Plan:
- Single-beat frame, LANES=4, first=last=1, a={1,2,3,4}, w={4'b0001,4'b1000,4'b0000,4'b0011} → 2-2+0+32: out_valid high 3 cycles after accept, out_data=32, out_sat=0.
- Three back-to-back beats: each beat a=all 10, w=all 4'b0000 except lane0 4'b0010 (+40 per beat) → out_data=120 after the 3rd beat+3 cycles; no bubbles on in_ready.
- Positive saturation: a=all 8'h7F, w=all 4'b0111, one-beat frame (raw 65024) → out_data=32767, out_sat=1. Next frame a=all 1, w=all 4'b0000 except lane0 4'b0000→1? Use w lane0=4'b0001 → out_data=2, out_sat=0 (sticky cleared).
- Negative saturation then recovery within a frame: beat1 a=all 8'h80, w=all 4'b0111 (raw -65536 → -32768); beat2 a=all 8'h80, w=all 4'b1111 (+65536) → out_data=32767, out_sat=1. This proves per-beat clamping.
- Backpressure: hold out_ready=0 for 5 cycles with the result pending and in_valid=1 → in_ready=0, out_data stable, no beats lost. Then out_ready=1 → next frame's result follows, with simultaneous pop/load keeping out_valid=1.
- Reset mid-frame: after 2 beats of a 4-beat frame, assert reset 1 cycle, then send a one-beat frame a=all 1, w=all 4'b0001 → out_data=8, out_sat=0, with no stale output emitted.

Source files
------------

// File: rtl/bitnet_dot_acc_if.sv
// Stream bundle for bitnet_dot_acc: beat input (activations + FP4 weights)
// and frame-result output, each with its own valid/ready pair.
interface bitnet_dot_acc_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned A_W   = 8,
  parameter int unsigned ACC_W = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_first;
  logic                   in_last;
  logic [LANES*A_W-1:0]   a_vec;
  logic [LANES*4-1:0]     w_vec;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_W-1:0]       out_data;
  logic                   out_sat;

  // Upstream streamers and downstream requantiser side.
  modport master (
    output in_valid, in_first, in_last, a_vec, w_vec, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // The dot-product accumulator itself.
  modport slave (
    input  in_valid, in_first, in_last, a_vec, w_vec, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/bitnet_dot_acc.sv
// Pipelined LANES-wide int8 x FP4-E3M0 shift-add dot product with a saturating
// per-frame accumulator and a valid/ready frame-result output.
module bitnet_dot_acc #(
  parameter int unsigned LANES = 4,
  parameter int unsigned A_W   = 8,
  parameter int unsigned ACC_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  bitnet_dot_acc_if.slave bus
);

  localparam int unsigned TERM_W = A_W + 8;
  localparam int unsigned SUM_W  = TERM_W + $clog2(LANES);
  localparam int unsigned RAW_W  = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

  localparam logic signed [RAW_W-1:0] RAW_MAX =
    {{(RAW_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [RAW_W-1:0] RAW_MIN =
    {{(RAW_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  logic                     stall_c;
  logic                     accept_c;

  logic signed [TERM_W-1:0] term_c [LANES];
  logic signed [TERM_W-1:0] s1_term [LANES];
  logic                     s1_valid;
  logic                     s1_first;
  logic                     s1_last;

  logic signed [SUM_W-1:0]  sum_c;
  logic signed [SUM_W-1:0]  s2_sum;
  logic                     s2_valid;
  logic                     s2_first;
  logic                     s2_last;

  logic signed [RAW_W-1:0]  base_c;
  logic signed [RAW_W-1:0]  raw_c;
  logic                     pos_ovf_c;
  logic                     neg_ovf_c;
  logic signed [ACC_W-1:0]  next_c;
  logic                     sticky_next_c;

  logic signed [ACC_W-1:0]  acc;
  logic                     sticky;
  logic                     s3_valid;
  logic                     s3_last;
  logic signed [ACC_W-1:0]  s3_data;
  logic                     s3_sat;

  logic                     out_valid;
  logic [ACC_W-1:0]         out_data;
  logic                     out_sat;

  // A pending result that downstream refuses freezes the whole pipeline.
  assign stall_c      = out_valid & ~bus.out_ready;
  assign accept_c     = bus.in_valid & ~stall_c;
  assign bus.in_ready = ~stall_c;

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_sat   = out_sat;

  // Weight decode: 0000 is zero, anything else is +/- (a << exp); 1000 is -a.
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      term_c[i] = '0;
      if (bus.w_vec[i*4 +: 4] != 4'b0000) begin
        term_c[i] = TERM_W'($signed(bus.a_vec[i*A_W +: A_W])) <<< bus.w_vec[i*4 +: 3];
        if (bus.w_vec[i*4+3]) begin
          term_c[i] = -term_c[i];
        end
      end
    end
  end

  // S1: per-lane terms and beat framing.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
        s1_term[i] <= '0;
      end
    end else if (!stall_c) begin
      s1_valid <= accept_c;
      s1_first <= bus.in_first;
      s1_last  <= bus.in_last;
      for (int i = 0; i < int'(LANES); i++) begin
        s1_term[i] <= term_c[i];
      end
    end
  end

  // Lane reduction; the sum width grows by log2(LANES) so it is exact.
  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      sum_c = sum_c + SUM_W'(s1_term[i]);
    end
  end

  // S2: reduced beat sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_sum   <= '0;
    end else if (!stall_c) begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_sum   <= sum_c;
    end
  end

  // Accumulate at full width, then clamp every beat so later beats can recover.
  always_comb begin
    base_c        = s2_first ? '0 : RAW_W'(acc);
    raw_c         = base_c + RAW_W'(s2_sum);
    pos_ovf_c     = raw_c > RAW_MAX;
    neg_ovf_c     = raw_c < RAW_MIN;
    next_c        = ACC_W'(raw_c);
    if (pos_ovf_c) begin
      next_c = SAT_POS;
    end else if (neg_ovf_c) begin
      next_c = SAT_NEG;
    end
    sticky_next_c = (s2_first ? 1'b0 : sticky) | pos_ovf_c | neg_ovf_c;
  end

  // S3: accumulator/sticky update; a last beat hands off and clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      sticky   <= 1'b0;
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
      s3_data  <= '0;
      s3_sat   <= 1'b0;
    end else if (!stall_c) begin
      s3_valid <= s2_valid;
      s3_last  <= s2_last;
      if (s2_valid) begin
        s3_data <= next_c;
        s3_sat  <= sticky_next_c;
        acc     <= s2_last ? '0 : next_c;
        sticky  <= s2_last ? 1'b0 : sticky_next_c;
      end
    end
  end

  // Output register: holds while stalled, otherwise pops and/or reloads.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (!stall_c) begin
      out_valid <= s3_valid & s3_last;
      if (s3_valid && s3_last) begin
        out_data <= s3_data;
        out_sat  <= s3_sat;
      end
    end
  end

endmodule

// File: tb/tb_bitnet_dot_acc.sv
// Scoreboard bench for bitnet_dot_acc: directed frames plus random traffic
// checked against an integer model of the frame accumulation rules.
module tb_bitnet_dot_acc;
  localparam int unsigned LANES = 4;
  localparam int unsigned A_W   = 8;
  localparam int unsigned ACC_W = 16;
  localparam int ACC_HI = 32767;
  localparam int ACC_LO = -32768;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bitnet_dot_acc_if #(.LANES(LANES), .A_W(A_W), .ACC_W(ACC_W)) bus ();
  bitnet_dot_acc #(.LANES(LANES), .A_W(A_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { int data; bit sat; } exp_t;
  exp_t q[$];

  int checks   = 0;
  int failures = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  int m_acc    = 0;
  bit m_sticky = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int lane_term(input int a, input logic [3:0] w);
    int t;
    if (w == 4'b0000) return 0;
    t = a * (1 << w[2:0]);
    return w[3] ? -t : t;
  endfunction

  // Reference: exact frame sum, clamped after each beat, sticky per frame.
  task automatic model_beat(input logic [LANES*A_W-1:0] av, input logic [LANES*4-1:0] wv,
                            input bit first, input bit last);
    int sum;
    int raw;
    int clamped;
    bit oor;
    bit stk;
    logic signed [A_W-1:0] a_l;
    sum = 0;
    for (int i = 0; i < int'(LANES); i++) begin
      a_l = av[i*A_W +: A_W];
      sum += lane_term(int'(a_l), wv[i*4 +: 4]);
    end
    raw     = (first ? 0 : m_acc) + sum;
    oor     = (raw > ACC_HI) || (raw < ACC_LO);
    clamped = (raw > ACC_HI) ? ACC_HI : ((raw < ACC_LO) ? ACC_LO : raw);
    stk     = (first ? 1'b0 : m_sticky) | oor;
    if (last) begin
      q.push_back('{clamped, stk});
      m_acc    = 0;
      m_sticky = 1'b0;
    end else begin
      m_acc    = clamped;
      m_sticky = stk;
    end
  endtask

  // Drives one beat from a falling edge and holds it until accepted.
  task automatic send_beat(input logic [LANES*A_W-1:0] av, input logic [LANES*4-1:0] wv,
                           input bit first, input bit last, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a_vec    = av;
    bus.w_vec    = wv;
    bus.in_first = first;
    bus.in_last  = last;
    while (!done) begin
      #2;
      if (bus.in_ready) begin
        model_beat(av, wv, first, last);
        done = 1'b1;
      end else if (waits > 500) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=in_ready_low required=accept");
        done = 1'b1;
      end else begin
        waits++;
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
      bus.in_last  = 1'b0;
      bus.a_vec    = 32'($urandom);
      bus.w_vec    = 16'($urandom);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      n++;
    end
    check(name, q.size(), 0);
  endtask

  task automatic wait_out_valid(input string name);
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(name, bus.out_valid, 1);
  endtask

  // Monitor: drives out_ready, pops the scoreboard on each handshake and
  // checks that a stalled result holds steady.
  initial begin
    bit               prev_stall;
    logic [ACC_W-1:0] prev_data;
    logic             prev_sat;
    exp_t             e;
    prev_stall    = 1'b0;
    prev_data     = '0;
    prev_sat      = 1'b0;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom % 4) != 0;
        default: bus.out_ready = 1'b0;
      endcase
      #1;
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", bus.out_valid, 1);
          check("hold_data", bus.out_data, prev_data);
          check("hold_sat", bus.out_sat, prev_sat);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%0d required=no_output",
                     $signed(bus.out_data));
          end else begin
            e = q.pop_front();
            check("out_data", $signed(bus.out_data), e.data);
            check("out_sat", bus.out_sat, e.sat);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_sat   = bus.out_sat;
      end
    end
  end

  initial begin
    int waits;
    int lat;
    bit frame_start;
    bit first;
    bit last;
    logic [LANES*4-1:0] w;

    bus.in_valid = 1'b0;
    bus.in_first = 1'b0;
    bus.in_last  = 1'b0;
    bus.a_vec    = '0;
    bus.w_vec    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #2;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_sat", bus.out_sat, 0);
    check("rst_in_ready", bus.in_ready, 1);

    // One-beat frame: 1*2 - 2 + 0 + 4*8 = 32, visible 3 edges after accept.
    send_beat({8'd4, 8'd3, 8'd2, 8'd1}, {4'b0011, 4'b0000, 4'b1000, 4'b0001}, 1, 1, waits);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus.in_valid = 1'b0;
      #2;
      if (bus.out_valid) begin
        lat = k - 1;
        break;
      end
    end
    check("latency", lat, 3);
    idle(3);

    // Three beats of +40 with no gaps.
    for (int b = 0; b < 3; b++) begin
      send_beat({4{8'd10}}, {4'b0000, 4'b0000, 4'b0000, 4'b0010}, b == 0, b == 2, waits);
      check("burst_no_wait", waits, 0);
    end
    idle(5);

    // Positive saturation, then a clean frame with sticky cleared.
    send_beat({4{8'h7F}}, {4{4'b0111}}, 1, 1, waits);
    send_beat({4{8'd1}}, {4'b0000, 4'b0000, 4'b0000, 4'b0001}, 1, 1, waits);
    idle(5);

    // Negative clamp then recovery inside one frame.
    send_beat({4{8'h80}}, {4{4'b0111}}, 1, 0, waits);
    send_beat({4{8'h80}}, {4{4'b1111}}, 0, 1, waits);
    drain("drain_directed");

    // Backpressure: A pending, B queued behind it, C offered while stalled.
    @(negedge clk);
    #3 rdy_mode = 2;
    send_beat({4{8'd1}}, {4{4'b0001}}, 1, 1, waits);
    send_beat(32'($urandom), 16'($urandom), 1, 1, waits);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_out_valid("bp_out_valid");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_first = 1'b1;
      bus.in_last  = 1'b1;
      #2;
      check("bp_in_ready", bus.in_ready, 0);
    end
    #1 rdy_mode = 0;
    send_beat(32'($urandom), 16'($urandom), 1, 1, waits);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    check("popload_valid", bus.out_valid, 1);
    drain("drain_bp");

    // Reset in the middle of a frame discards it silently.
    send_beat(32'($urandom), 16'($urandom), 1, 0, waits);
    send_beat(32'($urandom), 16'($urandom), 0, 0, waits);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    m_acc    = 0;
    m_sticky = 1'b0;
    #2;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    send_beat({4{8'd1}}, {4{4'b0001}}, 1, 1, waits);
    drain("drain_reset");

    // Random frames with bubbles, stray first flags and random backpressure.
    @(negedge clk);
    #3 rdy_mode = 1;
    frame_start = 1'b1;
    for (int n = 0; n < 400; n++) begin
      first = frame_start | (($urandom % 12) == 0);
      last  = ($urandom % 3) == 0;
      w     = 16'($urandom);
      if (($urandom % 5) == 0) w[3:0] = 4'b1000;
      send_beat(32'($urandom), w, first, last, waits);
      frame_start = last;
      if (($urandom % 4) == 0) idle(1 + int'($urandom % 2));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #3 rdy_mode = 0;
    drain("drain_random");
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
